issue_scoreboard: RTL and testbench

Issue-stage scoreboard between Decode and Execute of the pipelined MIPS core. Tracks outstanding register writes from in-flight instructions, detects RAW/WAW/structural hazards, and generates the `is_stall` that freezes Decode's ID/EX register. Forwards same-cycle writeback data onto the operand paths. Provides a drain sequence (stop issue until the pipeline is empty) for serialising instructions.

---
 rtl/issue_scoreboard_pkg.sv | 14 +
 rtl/issue_scoreboard_if.sv | 47 ++++
 rtl/issue_scoreboard_hazard_check.sv | 39 +++
 rtl/issue_scoreboard.sv | 151 +++++++++++++++
 tb/tb_issue_scoreboard.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_scoreboard_pkg.sv
`default_nettype none
// ---- issue_scoreboard_pkg : shared state encodings and constants (rev 1.0) ----
package issue_scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/issue_scoreboard_if.sv
`default_nettype none
// ---- issue_scoreboard_if : decode/writeback/execute signals of the issue stage (rev 1.0) ----
interface issue_scoreboard_if #(
    parameter int CW = 4
);
    logic          id_is_valid;
    logic [4:0]    id_is_addra;
    logic [4:0]    id_is_addrb;
    logic          id_is_usea;
    logic          id_is_useb;
    logic [4:0]    id_is_regdest;
    logic          id_is_writereg;
    logic          id_is_mem;
    logic          mem_busy;
    logic          flush;
    logic          drain_req;
    logic          wb_valid;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic [31:0]   reg_is_dataa;
    logic [31:0]   reg_is_datab;
    logic [31:0]   is_dataa;
    logic [31:0]   is_datab;
    logic          is_stall;
    logic          is_ex_valid;
    logic [CW-1:0] is_inflight;
    logic          drain_ack;
    logic          is_wb_err;

    modport master (
        output id_is_valid, id_is_addra, id_is_addrb, id_is_usea, id_is_useb,
               id_is_regdest, id_is_writereg, id_is_mem, mem_busy, flush,
               drain_req, wb_valid, wb_addr, wb_data, reg_is_dataa, reg_is_datab,
        input  is_dataa, is_datab, is_stall, is_ex_valid, is_inflight,
               drain_ack, is_wb_err
    );

    modport slave (
        input  id_is_valid, id_is_addra, id_is_addrb, id_is_usea, id_is_useb,
               id_is_regdest, id_is_writereg, id_is_mem, mem_busy, flush,
               drain_req, wb_valid, wb_addr, wb_data, reg_is_dataa, reg_is_datab,
        output is_dataa, is_datab, is_stall, is_ex_valid, is_inflight,
               drain_ack, is_wb_err
    );

endinterface
`default_nettype wire

// File: rtl/issue_scoreboard_hazard_check.sv
`default_nettype none
// ---- hazard_check : combinational RAW/WAW/structural/capacity hazard evaluation (rev 1.0) ----
module hazard_check
    import issue_scoreboard_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int CW           = 4
) (
    input  wire logic [31:0]   i_busy_eff,
    input  wire logic          i_valid,
    input  wire logic [4:0]    i_addra,
    input  wire logic [4:0]    i_addrb,
    input  wire logic          i_usea,
    input  wire logic          i_useb,
    input  wire logic [4:0]    i_regdest,
    input  wire logic          i_writereg,
    input  wire logic          i_mem,
    input  wire logic          i_mem_busy,
    input  wire logic [CW-1:0] i_inflight,
    output logic               o_raw,
    output logic               o_waw,
    output logic               o_strct,
    output logic               o_full
);

    logic w_raw_a;
    logic w_raw_b;

    // $0 is never a real dependency even though decode may flag it as used
    assign w_raw_a = i_usea & (i_addra != REG_ZERO) & i_busy_eff[i_addra];
    assign w_raw_b = i_useb & (i_addrb != REG_ZERO) & i_busy_eff[i_addrb];

    assign o_raw   = i_valid & (w_raw_a | w_raw_b);
    assign o_waw   = i_valid & i_writereg & (i_regdest != REG_ZERO) & i_busy_eff[i_regdest];
    assign o_strct = i_valid & i_mem & i_mem_busy;
    assign o_full  = i_valid & i_writereg & (i_inflight == CW'(MAX_INFLIGHT));

endmodule
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ---- issue_scoreboard : busy-register scoreboard, stall generation, WB forwarding, drain FSM (rev 1.0) ----
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int CW           = 4
) (
    input  wire logic          clock,
    input  wire logic          reset,
    issue_scoreboard_if.slave  sb
);

    logic [31:1]   r_busy;
    logic [CW-1:0] r_inflight;
    logic          r_ex_valid;
    logic          r_wb_err;
    state_t        r_state;
    state_t        w_state_nxt;

    logic [31:0]   w_busy;
    logic [31:0]   w_busy_eff;
    logic [31:0]   w_busy_nxt;
    logic          w_raw;
    logic          w_waw;
    logic          w_strct;
    logic          w_full;
    logic          w_notrun;
    logic          w_drain_ack;
    logic          w_stall;
    logic          w_issue;
    logic          w_alloc;
    logic          w_wb_live;
    logic          w_wb_hit;
    logic          w_wb_err;

    assign w_busy    = {r_busy, 1'b0};
    assign w_wb_live = sb.wb_valid & (sb.wb_addr != REG_ZERO);
    assign w_wb_hit  = w_wb_live & w_busy[sb.wb_addr];
    assign w_wb_err  = w_wb_live & ~w_busy[sb.wb_addr];

    // A register retiring this very cycle no longer blocks its consumers
    always_comb begin
        w_busy_eff = w_busy;
        if (sb.wb_valid) begin
            w_busy_eff[sb.wb_addr] = 1'b0;
        end
    end

    hazard_check #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CW           (CW)
    ) u_hazard_check (
        .i_busy_eff (w_busy_eff),
        .i_valid    (sb.id_is_valid),
        .i_addra    (sb.id_is_addra),
        .i_addrb    (sb.id_is_addrb),
        .i_usea     (sb.id_is_usea),
        .i_useb     (sb.id_is_useb),
        .i_regdest  (sb.id_is_regdest),
        .i_writereg (sb.id_is_writereg),
        .i_mem      (sb.id_is_mem),
        .i_mem_busy (sb.mem_busy),
        .i_inflight (r_inflight),
        .o_raw      (w_raw),
        .o_waw      (w_waw),
        .o_strct    (w_strct),
        .o_full     (w_full)
    );

    assign w_stall = sb.id_is_valid & (w_raw | w_waw | w_strct | w_full | w_notrun);
    assign w_issue = sb.id_is_valid & ~w_stall & ~sb.flush;
    assign w_alloc = w_issue & sb.id_is_writereg & (sb.id_is_regdest != REG_ZERO);

    // Clear before set so a same-edge reissue of the retiring register keeps it busy
    always_comb begin
        w_busy_nxt = w_busy;
        if (w_wb_hit) begin
            w_busy_nxt[sb.wb_addr] = 1'b0;
        end
        if (w_alloc) begin
            w_busy_nxt[sb.id_is_regdest] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy     <= '0;
            r_inflight <= '0;
            r_ex_valid <= 1'b0;
            r_wb_err   <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt[31:1];
            r_ex_valid <= w_issue;
            if (w_alloc && !w_wb_hit) begin
                r_inflight <= r_inflight + CW'(1);
            end else if (!w_alloc && w_wb_hit) begin
                r_inflight <= r_inflight - CW'(1);
            end
            if (w_wb_err) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_notrun    = 1'b1;
        w_drain_ack = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_notrun = 1'b0;
                if (sb.drain_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((r_inflight == '0) && !sb.mem_busy) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_drain_ack = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign sb.is_dataa    = (sb.wb_valid && (sb.wb_addr == sb.id_is_addra) && (sb.id_is_addra != REG_ZERO))
                            ? sb.wb_data : sb.reg_is_dataa;
    assign sb.is_datab    = (sb.wb_valid && (sb.wb_addr == sb.id_is_addrb) && (sb.id_is_addrb != REG_ZERO))
                            ? sb.wb_data : sb.reg_is_datab;
    assign sb.is_stall    = w_stall;
    assign sb.is_ex_valid = r_ex_valid;
    assign sb.is_inflight = r_inflight;
    assign sb.drain_ack   = w_drain_ack;
    assign sb.is_wb_err   = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ---- tb_issue_scoreboard : directed + random checks against a register-level reference model (rev 1.0) ----
module tb_issue_scoreboard;

    localparam int MAXI = 4;
    localparam int CW   = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    issue_scoreboard_if #(.CW(CW)) bus();

    issue_scoreboard #(
        .MAX_INFLIGHT (MAXI),
        .CW           (CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sb    (bus.slave)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // reference model: which registers await writeback, how many, drain progress
    bit m_busy [32];
    int m_infl;
    bit m_drain;
    bit m_ack;
    bit m_exv;
    bit m_werr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        m_infl  = 0;
        m_drain = 1'b0;
        m_ack   = 1'b0;
        m_exv   = 1'b0;
        m_werr  = 1'b0;
    endtask

    function automatic bit pending(input logic [4:0] r);
        return m_busy[r] && !(bus.wb_valid && bus.wb_addr == r);
    endfunction

    function automatic bit m_stall();
        bit h;
        if (!bus.id_is_valid) return 1'b0;
        h = (bus.id_is_usea && bus.id_is_addra != 0 && pending(bus.id_is_addra))
          || (bus.id_is_useb && bus.id_is_addrb != 0 && pending(bus.id_is_addrb))
          || (bus.id_is_writereg && bus.id_is_regdest != 0 && pending(bus.id_is_regdest))
          || (bus.id_is_mem && bus.mem_busy)
          || (bus.id_is_writereg && m_infl == MAXI)
          || m_drain || m_ack;
        return h;
    endfunction

    task automatic set_idle();
        bus.id_is_valid    = 1'b0;
        bus.id_is_addra    = 5'd0;
        bus.id_is_addrb    = 5'd0;
        bus.id_is_usea     = 1'b0;
        bus.id_is_useb     = 1'b0;
        bus.id_is_regdest  = 5'd0;
        bus.id_is_writereg = 1'b0;
        bus.id_is_mem      = 1'b0;
        bus.mem_busy       = 1'b0;
        bus.flush          = 1'b0;
        bus.drain_req      = 1'b0;
        bus.wb_valid       = 1'b0;
        bus.wb_addr        = 5'd0;
        bus.wb_data        = 32'd0;
        bus.reg_is_dataa   = $urandom;
        bus.reg_is_datab   = $urandom;
    endtask

    task automatic instr(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input bit wr, input bit mem);
        bus.id_is_valid    = 1'b1;
        bus.id_is_addra    = a;
        bus.id_is_addrb    = b;
        bus.id_is_usea     = 1'b1;
        bus.id_is_useb     = 1'b1;
        bus.id_is_regdest  = d;
        bus.id_is_writereg = wr;
        bus.id_is_mem      = mem;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] data);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = r;
        bus.wb_data  = data;
    endtask

    // let inputs settle mid-cycle and compare every output with the model
    task automatic settle();
        logic [31:0] ea;
        logic [31:0] eb;
        #2;
        ea = (bus.wb_valid && bus.wb_addr == bus.id_is_addra && bus.id_is_addra != 0) ? bus.wb_data : bus.reg_is_dataa;
        eb = (bus.wb_valid && bus.wb_addr == bus.id_is_addrb && bus.id_is_addrb != 0) ? bus.wb_data : bus.reg_is_datab;
        chk("stall",    32'(bus.is_stall),    32'(m_stall()));
        chk("dataa",    bus.is_dataa,         ea);
        chk("datab",    bus.is_datab,         eb);
        chk("ex_valid", 32'(bus.is_ex_valid), 32'(m_exv));
        chk("inflight", 32'(bus.is_inflight), 32'(m_infl));
        chk("drainack", 32'(bus.drain_ack),   32'(m_ack));
        chk("wb_err",   32'(bus.is_wb_err),   32'(m_werr));
    endtask

    task automatic tick();
        bit iss;
        int old;
        old = m_infl;
        iss = bus.id_is_valid && !m_stall() && !bus.flush;
        if (bus.wb_valid && bus.wb_addr != 0) begin
            if (m_busy[bus.wb_addr]) begin
                m_busy[bus.wb_addr] = 1'b0;
                m_infl--;
            end else begin
                m_werr = 1'b1;
            end
        end
        if (iss && bus.id_is_writereg && bus.id_is_regdest != 0) begin
            m_busy[bus.id_is_regdest] = 1'b1;
            m_infl++;
        end
        m_exv = iss;
        if (m_ack) begin
            m_ack = 1'b0;
        end else if (m_drain) begin
            if (old == 0 && !bus.mem_busy) begin
                m_drain = 1'b0;
                m_ack   = 1'b1;
            end
        end else if (bus.drain_req) begin
            m_drain = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic clear_all();
        for (int r = 1; r < 32; r++) begin
            if (m_busy[r]) begin
                set_idle();
                wb(5'(r), $urandom);
                cycle();
            end
        end
        set_idle();
        cycle();
    endtask

    initial begin
        int acks;
        int q[$];
        model_reset();
        set_idle();
        #12;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // reset state
        cycle();

        // add $3,$1,$2
        set_idle();
        instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        cycle();
        chk("add_inflight", 32'(bus.is_inflight), 32'd1);
        chk("add_exvalid",  32'(bus.is_ex_valid), 32'd1);

        // sub $4,$3,$1 stalls on $3, then issues with forwarded writeback
        set_idle();
        instr(5'd3, 5'd1, 5'd4, 1'b1, 1'b0);
        settle();
        chk("dep_stall", 32'(bus.is_stall), 32'd1);
        tick();
        wb(5'd3, 32'hDEADBEEF);
        settle();
        chk("dep_fwd",   bus.is_dataa,        32'hDEADBEEF);
        chk("dep_go",    32'(bus.is_stall),   32'd0);
        tick();
        chk("dep_infl",  32'(bus.is_inflight), 32'd1);

        // fill to capacity, fifth writer waits for a retirement
        clear_all();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            instr(5'd0, 5'd0, 5'(5 + i), 1'b1, 1'b0);
            cycle();
        end
        set_idle();
        instr(5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        settle();
        chk("full_stall", 32'(bus.is_stall), 32'd1);
        tick();
        wb(5'd5, 32'h1234);
        settle();
        chk("full_same_edge", 32'(bus.is_stall), 32'd1);
        tick();
        bus.wb_valid = 1'b0;
        settle();
        chk("full_released", 32'(bus.is_stall), 32'd0);
        tick();
        clear_all();
        set_idle();
        instr(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        cycle();
        chk("r0_no_count", 32'(bus.is_inflight), 32'd0);

        // structural hazard on the memory unit, then flush
        set_idle();
        instr(5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
        bus.mem_busy = 1'b1;
        cycle();
        bus.mem_busy = 1'b0;
        cycle();
        set_idle();
        instr(5'd1, 5'd2, 5'd13, 1'b1, 1'b0);
        bus.flush = 1'b1;
        settle();
        chk("flush_nostall", 32'(bus.is_stall), 32'd0);
        tick();
        chk("flush_exv", 32'(bus.is_ex_valid), 32'd0);
        chk("flush_infl", 32'(bus.is_inflight), 32'd0);

        // drain with two writes outstanding
        set_idle(); instr(5'd0, 5'd0, 5'd10, 1'b1, 1'b0); cycle();
        set_idle(); instr(5'd0, 5'd0, 5'd11, 1'b1, 1'b0); cycle();
        set_idle(); instr(5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
        bus.drain_req = 1'b1;
        settle();
        chk("drain_req_cycle", 32'(bus.is_stall), 32'd0);
        tick();
        bus.drain_req = 1'b0;
        settle();
        chk("drain_blocks", 32'(bus.is_stall), 32'd1);
        tick();
        wb(5'd10, 32'h10); cycle();
        wb(5'd11, 32'h11); cycle();
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            set_idle();
            settle();
            if (bus.drain_ack) acks++;
            tick();
        end
        chk("drain_ack_once", 32'(acks), 32'd1);
        set_idle(); instr(5'd1, 5'd2, 5'd14, 1'b1, 1'b0);
        settle();
        chk("drain_resume", 32'(bus.is_stall), 32'd0);
        tick();
        clear_all();

        // writeback to an idle register
        set_idle();
        wb(5'd9, 32'h99);
        cycle();
        chk("wb_err_set", 32'(bus.is_wb_err), 32'd1);
        chk("wb_err_infl", 32'(bus.is_inflight), 32'd0);

        // randomized traffic on a small register window
        for (int n = 0; n < 400; n++) begin
            set_idle();
            bus.id_is_valid    = ($urandom % 4) != 0;
            bus.id_is_addra    = 5'($urandom % 8);
            bus.id_is_addrb    = 5'($urandom % 8);
            bus.id_is_usea     = 1'($urandom);
            bus.id_is_useb     = 1'($urandom);
            bus.id_is_regdest  = 5'($urandom % 8);
            bus.id_is_writereg = ($urandom % 4) != 0;
            bus.id_is_mem      = ($urandom % 4) == 0;
            bus.mem_busy       = ($urandom % 5) == 0;
            bus.flush          = ($urandom % 10) == 0;
            bus.drain_req      = ($urandom % 25) == 0;
            if ($urandom % 2) begin
                q.delete();
                for (int r = 1; r < 32; r++) if (m_busy[r]) q.push_back(r);
                if (q.size() > 0 && ($urandom % 16) != 0)
                    wb(5'(q[$urandom_range(q.size() - 1, 0)]), $urandom);
                else
                    wb(5'($urandom % 8), $urandom);
            end
            cycle();
        end

        // asynchronous reset in the middle of a drain
        clear_all();
        set_idle(); instr(5'd0, 5'd0, 5'd12, 1'b1, 1'b0); cycle();
        set_idle(); bus.drain_req = 1'b1; cycle();
        set_idle(); cycle();
        set_idle(); cycle();
        set_idle();
        instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        bus.mem_busy = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_exv",   32'(bus.is_ex_valid), 32'd0);
        chk("rst_infl",  32'(bus.is_inflight), 32'd0);
        chk("rst_ack",   32'(bus.drain_ack),   32'd0);
        chk("rst_werr",  32'(bus.is_wb_err),   32'd0);
        chk("rst_stall", 32'(bus.is_stall),    32'd1);
        model_reset();
        reset = 1'b1;
        set_idle();
        instr(5'd1, 5'd2, 5'd12, 1'b1, 1'b0);
        cycle();
        set_idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
